// File: rtl/dest_reg_bank.sv
// Destination register bank: synchronises the load strobe and select code,
// waits for the code to settle, then writes one of 8 entries. Has a registered read port.
module dest_reg_bank #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LDD,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic [WIDTH-1:0] DIN,
    input  logic [2:0]       RADDR,
    output logic [WIDTH-1:0] RDATA,
    output logic [7:0]       VLD,
    output logic             WR_DONE,
    output logic             BUSY,
    output logic             ERR,
    output logic             OVR,
    input  logic             CLR_ERR
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_ldd_s1, r_ldd_s2, r_ldd_s3;
    logic [2:0]       r_sel_s1, r_sel_s2;
    logic [WIDTH-1:0] r_din_hold;
    logic [WIDTH-1:0] r_mem [8];
    logic [WIDTH-1:0] r_rdata;
    logic [7:0]       r_vld;
    logic             r_wr_done, r_busy, r_err, r_ovr;

    logic             w_ld_pulse;
    logic             w_bad_code;

    assign w_ld_pulse = r_ldd_s2 & ~r_ldd_s3;
    // 000 and 111 never come out of the upstream sequence, so they mark a fault.
    assign w_bad_code = (r_sel_s2 == 3'b000) || (r_sel_s2 == 3'b111);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ldd_s1   <= 1'b0;
            r_ldd_s2   <= 1'b0;
            r_ldd_s3   <= 1'b0;
            r_sel_s1   <= '0;
            r_sel_s2   <= '0;
            r_din_hold <= '0;
            for (int i = 0; i < 8; i++) r_mem[i] <= '0;
            r_rdata    <= '0;
            r_vld      <= '0;
            r_wr_done  <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_ldd_s1  <= LDD;
            r_ldd_s2  <= r_ldd_s1;
            r_ldd_s3  <= r_ldd_s2;
            r_sel_s1  <= {S2, S1, S0};
            r_sel_s2  <= r_sel_s1;
            r_rdata   <= r_mem[RADDR];
            r_wr_done <= 1'b0;

            // Clear first so a set on the same edge takes priority.
            if (CLR_ERR) begin
                r_err <= 1'b0;
                r_ovr <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ld_pulse) begin
                        r_din_hold <= DIN;
                        r_cnt      <= CW'(SETTLE - 1);
                        r_state    <= ST_SETTLE;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (w_ld_pulse) r_ovr <= 1'b1;
                    if (r_cnt == '0) begin
                        if (!w_bad_code) begin
                            r_mem[r_sel_s2] <= r_din_hold;
                            r_vld[r_sel_s2] <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_wr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RDATA   = r_rdata;
    assign VLD     = r_vld;
    assign WR_DONE = r_wr_done;
    assign BUSY    = r_busy;
    assign ERR     = r_err;
    assign OVR     = r_ovr;

endmodule

// File: tb/tb_dest_reg_bank.sv
// Scoreboard bench for dest_reg_bank: stimulus queues expected write completions
// and read data; a monitor checks them as WR_DONE / read results appear.
module tb_dest_reg_bank;

    localparam int ST = 4;

    logic       CLK = 1'b0;
    logic       RST, LDD, S0, S1, S2, CLR_ERR;
    logic [7:0] DIN, RDATA, VLD;
    logic [2:0] RADDR;
    logic       WR_DONE, BUSY, ERR, OVR;

    typedef struct {
        int         cyc;
        logic [7:0] vld;
        logic       err;
        logic       ovr;
    } wexp_t;

    wexp_t      wq[$];
    logic [7:0] rq[$];
    wexp_t      w_m;
    logic [7:0] e_m;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic rd_issue = 1'b0;
    logic rd_due   = 1'b0;

    dest_reg_bank #(.WIDTH(8), .SETTLE(ST)) dut (
        .CLK(CLK), .RST(RST), .LDD(LDD), .S0(S0), .S1(S1), .S2(S2),
        .DIN(DIN), .RADDR(RADDR), .RDATA(RDATA), .VLD(VLD),
        .WR_DONE(WR_DONE), .BUSY(BUSY), .ERR(ERR), .OVR(OVR), .CLR_ERR(CLR_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        rd_due <= rd_issue;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT presents a result.
    always @(negedge CLK) begin
        if (rd_due) begin
            if (rq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rd_unexpected: read result with empty queue (cycle %0d)", cyc);
            end else begin
                e_m = rq.pop_front();
                cmp("rdata", {24'h0, RDATA}, {24'h0, e_m});
            end
        end
        if (WR_DONE) begin
            if (wq.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_done_unexpected: WR_DONE=1 expected none (cycle %0d)", cyc);
            end else begin
                w_m = wq.pop_front();
                cmp("wr_done_cycle", cyc, w_m.cyc);
                cmp("wr_vld", {24'h0, VLD}, {24'h0, w_m.vld});
                cmp("wr_err", {31'h0, ERR}, {31'h0, w_m.err});
                cmp("wr_ovr", {31'h0, OVR}, {31'h0, w_m.ovr});
            end
        end
    end

    task automatic push_wr(input int c, input logic [7:0] v, input logic e, input logic o);
        wexp_t w;
        w.cyc = c; w.vld = v; w.err = e; w.ovr = o;
        wq.push_back(w);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
        RADDR = a;
        rq.push_back(exp);
        rd_issue = 1'b1;
        @(negedge CLK);
        rd_issue = 1'b0;
    endtask

    // Full strobe: LDD high 4 cycles, low 6; write completes ST+3 edges after the rise.
    task automatic strobe(input logic [7:0] d, input logic [2:0] s,
                          input logic [7:0] v, input logic e, input logic o);
        push_wr(cyc + 3 + ST, v, e, o);
        DIN = d; {S2, S1, S0} = s; LDD = 1'b1;
        repeat (4) @(negedge CLK);
        LDD = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic chk_st(input string tag, input logic [7:0] v, input logic b,
                          input logic e, input logic o);
        cmp({tag, "_vld"},  {24'h0, VLD},  {24'h0, v});
        cmp({tag, "_busy"}, {31'h0, BUSY}, {31'h0, b});
        cmp({tag, "_err"},  {31'h0, ERR},  {31'h0, e});
        cmp({tag, "_ovr"},  {31'h0, OVR},  {31'h0, o});
    endtask

    task automatic clr_err();
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST = 1'b0; LDD = 1'b0; {S2, S1, S0} = 3'b100; DIN = '0;
        RADDR = '0; CLR_ERR = 1'b0;
        repeat (3) @(negedge CLK);
        chk_st("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        cmp("reset_wr_done", {31'h0, WR_DONE}, 32'h0);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) do_read(3'(i), 8'h00);

        // Basic write: code moves 100 -> 110 together with the LDD rise.
        strobe(8'h5A, 3'b110, 8'h40, 1'b0, 1'b0);
        do_read(3'd6, 8'h5A);

        // Rotation through 110, 010, 011 with an overwrite of entry 6.
        strobe(8'h11, 3'b110, 8'h40, 1'b0, 1'b0);
        strobe(8'h22, 3'b010, 8'h44, 1'b0, 1'b0);
        strobe(8'h33, 3'b011, 8'h4C, 1'b0, 1'b0);
        do_read(3'd6, 8'h11);
        do_read(3'd2, 8'h22);
        do_read(3'd3, 8'h33);

        // Illegal codes: write suppressed, ERR sticky until cleared.
        strobe(8'hFF, 3'b111, 8'h4C, 1'b1, 1'b0);
        chk_st("err111", 8'h4C, 1'b0, 1'b1, 1'b0);
        clr_err();
        cmp("err_cleared", {31'h0, ERR}, 32'h0);
        strobe(8'hEE, 3'b000, 8'h4C, 1'b1, 1'b0);
        clr_err();
        cmp("err000_cleared", {31'h0, ERR}, 32'h0);
        do_read(3'd7, 8'h00);
        do_read(3'd0, 8'h00);

        // Overrun: second ld_pulse is sampled on the write edge itself.
        n = cyc;
        push_wr(n + 3 + ST, 8'h6C, 1'b0, 1'b1);
        DIN = 8'h55; {S2, S1, S0} = 3'b101; LDD = 1'b1;
        repeat (2) @(negedge CLK);
        LDD = 1'b0;
        repeat (2) @(negedge CLK);
        cmp("ovr_busy", {31'h0, BUSY}, 32'h1);
        DIN = 8'hAA; LDD = 1'b1;
        repeat (3) @(negedge CLK);
        LDD = 1'b0;
        repeat (8) @(negedge CLK);
        chk_st("ovr", 8'h6C, 1'b0, 1'b0, 1'b1);
        do_read(3'd5, 8'h55);
        clr_err();
        cmp("ovr_cleared", {31'h0, OVR}, 32'h0);

        // Reset in the middle of SETTLE: write aborted, no WR_DONE.
        DIN = 8'h99; {S2, S1, S0} = 3'b100; LDD = 1'b1;
        repeat (2) @(negedge CLK);
        LDD = 1'b0;
        repeat (2) @(negedge CLK);
        cmp("midrst_busy_before", {31'h0, BUSY}, 32'h1);
        RST = 1'b0;
        #1;
        chk_st("midrst_async", 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (8) @(negedge CLK);
        chk_st("midrst_after", 8'h00, 1'b0, 1'b0, 1'b0);
        cmp("midrst_wr_done", {31'h0, WR_DONE}, 32'h0);
        do_read(3'd4, 8'h00);
        do_read(3'd6, 8'h00);

        // Same-address collision: read on the write edge sees the old value.
        strobe(8'h77, 3'b001, 8'h02, 1'b0, 1'b0);
        do_read(3'd1, 8'h77);
        n = cyc;
        push_wr(n + 3 + ST, 8'h02, 1'b0, 1'b0);
        DIN = 8'h88; LDD = 1'b1;
        repeat (2 + ST) @(negedge CLK);
        do_read(3'd1, 8'h77);
        do_read(3'd1, 8'h88);
        LDD = 1'b0;
        repeat (6) @(negedge CLK);

        cmp("wr_queue_drained", wq.size(), 32'h0);
        cmp("rd_queue_drained", rq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dest_reg_bank.md
Name: dest_reg_bank

Overview:
- Destination register bank that consumes the select code S2..S0 produced by the destination-select stage, and that stage's load strobe LDD.
- On each LDD rising edge it captures DIN and, once the select code has settled, writes DIN into one of 8 entries addressed by {S2,S1,S0}.
- Provides a registered read port, per-entry valid bits and sticky error flags.

Parameters:
- WIDTH, 8, data width of DIN, RDATA and each entry.
- SETTLE, 2, CLK cycles spent in SETTLE before the write (minimum 1).

Ports:
- CLK  in  1  system clock; all flops rising-edge.
- RST  in  1  asynchronous, active-low reset.
- LDD  in  1  load strobe; asynchronous to CLK, level.
- S0  in  1  select bit 0 (address bit 0), asynchronous.
- S1  in  1  select bit 1 (address bit 1), asynchronous.
- S2  in  1  select bit 2 (address bit 2), asynchronous.
- DIN  in  WIDTH  write data; stable from LDD rise until the load pulse edge.
- RADDR  in  3  read address.
- RDATA  out  WIDTH  registered read data.
- VLD  out  8  per-entry written flags.
- WR_DONE  out  1  one-cycle pulse after each completed write.
- BUSY  out  1  high in SETTLE.
- ERR  out  1  sticky: settled code was 000 or 111, write suppressed.
- OVR  out  1  sticky: load pulse arrived while BUSY.
- CLR_ERR  in  1  synchronous clear of ERR and OVR.

Behaviour:
- Reset (RST low, async): all of the following clear to 0.
  - Sync flops, FSM (state = IDLE), counter, din_hold.
  - All 8 entries, RDATA, VLD, WR_DONE, BUSY, ERR, OVR.
- Synchronisers:
  - LDD goes through a 2-FF chain ldd_s1→ldd_s2, plus a history flop ldd_s3.
  - ld_pulse = ldd_s2 & ~ldd_s3.
  - {S2,S1,S0} goes through its own 2-FF chain to sel_s2.
- Load latency: LDD rises before edge e0.
  - e0: ldd_s1 = 1.
  - e1: ldd_s2 = 1, so ld_pulse is high during the following cycle.
  - e2: din_hold <= DIN; state <= SETTLE; cnt <= SETTLE-1.
- FSM, IDLE: on ld_pulse go to SETTLE as above; otherwise stay.
- FSM, SETTLE: BUSY = 1; cnt decrements each edge. At the edge where cnt == 0:
  - If sel_s2 ∉ {000,111}: mem[sel_s2] <= din_hold; VLD[sel_s2] <= 1.
  - Otherwise: no write; ERR <= 1.
  - In both cases: state <= IDLE; WR_DONE = 1 for exactly the next cycle.
  - With SETTLE=2 the write occurs at e4.
- Overrun: a ld_pulse seen while in SETTLE sets OVR.
  - That load is dropped.
  - din_hold and cnt are unaffected.
- Re-arm: a new load needs LDD low long enough for ldd_s3 to return to 0 (≥2 CLK low); shorter low pulses may be missed.
- Overwrite: writing an entry that is already valid replaces its data; VLD stays 1.
- Read port:
  - RDATA <= mem[RADDR] every edge; 1-cycle latency.
  - Read and write to the same address on the same edge returns the old data; new data appears one cycle later.
- CLR_ERR:
  - Clears ERR and OVR at the next edge.
  - If a set condition occurs on that same edge, set wins.
- Mid-operation reset: an assertion during SETTLE aborts the write; no WR_DONE.
- Address mapping:
  - The upstream select sequence from its reset state visits codes {S2,S1,S0} = 100, 110, 010, 011, 001, 101, then repeats.
  - Codes 000 and 111 never occur in normal operation and are treated as errors.

Test Plan:
- Reset/read: hold RST low 3 cycles, release, read RADDR 0..7 → RDATA=0, VLD=0x00, ERR=OVR=BUSY=0.
- Basic write latency: S=100 static; DIN=0x5A; raise LDD before e0, S→110 at the same time → WR_DONE high in the cycle after e4, mem[6]=0x5A, VLD=0x40.
- Rotation: three strobes (≥4 CLK high, ≥4 CLK low) with DIN 0x11/0x22/0x33 and codes advancing 110→010→011 → mem[6]=0x11, mem[2]=0x22, mem[3]=0x33, VLD=0x4C.
- Error code: settled code 111 on a strobe, DIN=0xFF → no write, VLD unchanged, ERR=1, WR_DONE still pulses; CLR_ERR pulse → ERR=0.
- Overrun: second LDD rise arrives so its ld_pulse lands while BUSY (SETTLE=4) → first write completes, second dropped, OVR=1.
- Reset mid-op: assert RST during SETTLE → no write, WR_DONE never pulses, all outputs 0; same-address read/write collision returns the old value, then the new value one cycle later.
